// File: rtl/ppu_shifter_types_pkg.sv
// ppu_shifter_types_pkg: background pixel shifter state encoding.
package ppu_shifter_types_pkg;
    typedef enum logic [1:0] {
        SHIFTER_IDLE,
        SHIFTER_DISCARD,
        SHIFTER_SHIFT,
        SHIFTER_DONE
    } shifter_state_t;
endpackage

// File: rtl/ppu_types_pkg.sv
// ppu_types_pkg: shared PPU pixel types and screen geometry.
package ppu_types_pkg;
    localparam int GB_SCREEN_WIDTH = 160;
    typedef logic [1:0] color_id_t;
    typedef struct packed {
        color_id_t color;
    } pixel_t;
endpackage

// File: rtl/bg_pixel_shifter_if.sv
// bg_pixel_shifter_if: fetcher push port plus pixel output toward the LCD/mixer.
interface bg_pixel_shifter_if #(parameter int NUM_PIXELS = 8);
    import ppu_types_pkg::*;
    logic                       write_en;
    pixel_t [NUM_PIXELS-1:0]    write_data;
    logic                       empty;
    logic                       pix_valid;
    color_id_t                  pix_color;
    logic [7:0]                 pix_x;
    logic                       line_done;
    modport master (output write_en, write_data, input empty, pix_valid, pix_color, pix_x, line_done);
    modport slave  (input write_en, write_data, output empty, pix_valid, pix_color, pix_x, line_done);
endinterface

// File: rtl/pixel_buf8.sv
// pixel_buf8: 8-entry parallel-load, serial-read pixel buffer with overflow flag.
module pixel_buf8
    import ppu_types_pkg::*;
#(
    parameter int NUM_PIXELS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write_en,
    input  pixel_t [NUM_PIXELS-1:0] write_data,
    input  logic                    pop,
    output pixel_t                  rd_data,
    output logic                    empty,
    output logic                    overflow_err
);
    pixel_t [NUM_PIXELS-1:0] mem_q, mem_d;
    logic [3:0] count_q, count_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic       ovf_q, ovf_d;
    logic       push, do_pop;

    // A flush drops a coincident push without flagging it as an overflow.
    always_comb begin
        push     = write_en && count_q == 4'd0 && !clear;
        do_pop   = pop && count_q != 4'd0;
        mem_d    = push ? write_data : mem_q;
        count_d  = clear ? 4'd0 : push ? 4'(NUM_PIXELS) : do_pop ? count_q - 4'd1 : count_q;
        rd_ptr_d = (clear || push) ? 3'd0 : do_pop ? rd_ptr_q + 3'd1 : rd_ptr_q;
        ovf_d    = ovf_q || (write_en && count_q != 4'd0 && !clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            count_q  <= 4'd0;
            rd_ptr_q <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data      = mem_q[rd_ptr_q];
    assign empty        = count_q == 4'd0;
    assign overflow_err = ovf_q;
endmodule

// File: rtl/bg_pixel_shifter.sv
// bg_pixel_shifter: background FIFO consumer; drops SCX fine-scroll pixels and
// emits one registered pixel per dot during mode 3 until the line is complete.
module bg_pixel_shifter
    import ppu_types_pkg::*;
    import ppu_shifter_types_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int LINE_WIDTH = GB_SCREEN_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                mode3_active,
    input  logic                stall,
    input  logic [2:0]          scx_fine,
    bg_pixel_shifter_if.slave   bus,
    output logic                overflow_err
);
    shifter_state_t state_q, state_d;
    logic [2:0] discard_q, discard_d;
    logic [7:0] x_q, x_d;
    logic       pix_valid_q, pix_valid_d;
    color_id_t  pix_color_q, pix_color_d;
    logic [7:0] pix_x_q, pix_x_d;
    logic       line_done_q, line_done_d;
    logic       empty, pop, shift_pop, disc_pop, last;
    pixel_t     rd_data;

    pixel_buf8 #(.NUM_PIXELS(NUM_PIXELS)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .clear        (flush),
        .write_en     (bus.write_en),
        .write_data   (bus.write_data),
        .pop          (pop),
        .rd_data      (rd_data),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    assign pop       = mode3_active && !stall && !flush && !empty &&
                       (state_q == SHIFTER_DISCARD || state_q == SHIFTER_SHIFT);
    assign shift_pop = pop && state_q == SHIFTER_SHIFT;
    assign disc_pop  = pop && state_q == SHIFTER_DISCARD;
    assign last      = x_q == 8'(LINE_WIDTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SHIFTER_IDLE;
            discard_q   <= 3'd0;
            x_q         <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
            pix_x_q     <= 8'd0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            x_q         <= x_d;
            pix_valid_q <= pix_valid_d;
            pix_color_q <= pix_color_d;
            pix_x_q     <= pix_x_d;
            line_done_q <= line_done_d;
        end
    end

    always_comb begin
        state_d = flush ? (scx_fine != 3'd0 ? SHIFTER_DISCARD : SHIFTER_SHIFT) :
                  (disc_pop && discard_q == 3'd1) ? SHIFTER_SHIFT :
                  (shift_pop && last) ? SHIFTER_DONE : state_q;
    end

    // x stops at the last column; DONE blocks any further pop.
    always_comb begin
        discard_d   = flush ? scx_fine : disc_pop ? discard_q - 3'd1 : discard_q;
        x_d         = flush ? 8'd0 : (shift_pop && !last) ? x_q + 8'd1 : x_q;
        pix_valid_d = shift_pop;
        pix_color_d = shift_pop ? rd_data.color : pix_color_q;
        pix_x_d     = shift_pop ? x_q : pix_x_q;
        line_done_d = !flush && (line_done_q || (shift_pop && last));
    end

    assign bus.empty     = empty;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_color = pix_color_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.line_done = line_done_q;
endmodule

// File: tb/tb_bg_pixel_shifter.sv
// tb_bg_pixel_shifter: scoreboard bench; a line-level model predicts the visible
// pixel sequence from pushed tiles and fine scroll, a monitor checks each output.
module tb_bg_pixel_shifter;
    import ppu_types_pkg::*;

    localparam int LINE = 160;

    typedef struct {
        int x;
        int c;
    } exp_t;

    logic       clk = 0;
    logic       reset = 0;
    logic       flush = 0;
    logic       mode3_active = 0;
    logic       stall = 0;
    logic [2:0] scx_fine = 0;
    logic       overflow_err;

    bg_pixel_shifter_if bus();

    bg_pixel_shifter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .mode3_active (mode3_active),
        .stall        (stall),
        .scx_fine     (scx_fine),
        .bus          (bus),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   disc_rem = 0;
    int   x_exp = 0;
    int   last_x = -1;
    int   total_pulses = 0;
    bit   rand_en = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) begin
            stall = $urandom_range(0, 4) == 0;
            mode3_active = $urandom_range(0, 7) != 0;
        end
    endtask

    // Line model: fine-scroll pixels are skipped, the rest map to x in push order.
    task automatic model_push(input pixel_t [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (disc_rem > 0) disc_rem--;
            else if (x_exp < LINE) begin
                exp_q.push_back('{x: x_exp, c: int'(d[i].color)});
                x_exp++;
            end
        end
    endtask

    function automatic pixel_t [7:0] rand_tile();
        pixel_t [7:0] t;
        for (int i = 0; i < 8; i++) t[i].color = color_id_t'($urandom_range(0, 3));
        return t;
    endfunction

    task automatic do_flush(input logic [2:0] s);
        flush = 1;
        scx_fine = s;
        tick();
        flush = 0;
        disc_rem = int'(s);
        x_exp = 0;
        last_x = -1;
    endtask

    task automatic push_tile(input pixel_t [7:0] d);
        int n = 0;
        while (!bus.empty && n < 400) begin
            tick();
            n++;
        end
        if (!bus.empty) check("push_wait_empty", int'(bus.empty), 1);
        bus.write_en = 1;
        bus.write_data = d;
        tick();
        bus.write_en = 0;
        model_push(d);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.pix_valid) begin
                total_pulses++;
                last_x = int'(bus.pix_x);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pixel: got pix_x=%0d color=%0d, required no pixel", bus.pix_x, bus.pix_color);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_x", int'(bus.pix_x), e.x);
                    check("pix_color", int'(bus.pix_color), e.c);
                    check("line_done_with_pixel", int'(bus.line_done), int'(e.x == LINE - 1));
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
        check({tag, "_pix_color"}, int'(bus.pix_color), 0);
        check({tag, "_pix_x"}, int'(bus.pix_x), 0);
        check({tag, "_line_done"}, int'(bus.line_done), 0);
        check({tag, "_empty"}, int'(bus.empty), 1);
        check({tag, "_overflow"}, int'(overflow_err), 0);
    endtask

    initial begin
        pixel_t [7:0] t;
        int p0;
        int n;
        fork
            monitor();
        join_none
        bus.write_en = 0;
        bus.write_data = '0;
        #1 reset = 1;
        #2 check_reset_outputs("reset");
        tick();
        tick();
        reset = 0;
        tick();
        mode3_active = 1;

        do_flush(3'd0);
        for (int i = 0; i < 8; i++) t[i].color = color_id_t'(3 - (i % 4));
        push_tile(t);
        check("empty_after_push", int'(bus.empty), 0);
        drain();
        check("empty_after_tile", int'(bus.empty), 1);

        do_flush(3'd5);
        push_tile(rand_tile());
        push_tile(rand_tile());
        drain();

        do_flush(3'd0);
        push_tile(rand_tile());
        n = 0;
        while (last_x < 2 && n < 50) begin
            tick();
            n++;
        end
        check("reached_pix2", int'(last_x >= 2), 1);
        stall = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pix_valid_during_stall", int'(bus.pix_valid), 0);
        end
        stall = 0;
        drain();

        do_flush(3'd0);
        p0 = total_pulses;
        rand_en = 1;
        while (x_exp < LINE) push_tile(rand_tile());
        drain();
        rand_en = 0;
        stall = 0;
        mode3_active = 1;
        check("line_done_after_line", int'(bus.line_done), 1);
        check("pulses_per_line", total_pulses - p0, LINE);
        check("empty_before_extra_push", int'(bus.empty), 1);
        push_tile(rand_tile());
        repeat (5) tick();
        check("empty_after_extra_push", int'(bus.empty), 0);
        check("line_done_held", int'(bus.line_done), 1);
        check("no_pulse_after_done", total_pulses - p0, LINE);

        for (int k = 0; k < 3; k++) begin
            do_flush(3'($urandom_range(0, 7)));
            rand_en = 1;
            while (x_exp < LINE) push_tile(rand_tile());
            drain();
            rand_en = 0;
            stall = 0;
            mode3_active = 1;
            check("line_done_random_scx", int'(bus.line_done), 1);
        end

        do_flush(3'd0);
        mode3_active = 0;
        push_tile(rand_tile());
        mode3_active = 1;
        repeat (4) tick();
        mode3_active = 0;
        bus.write_en = 1;
        bus.write_data = rand_tile();
        tick();
        bus.write_en = 0;
        check("overflow_set", int'(overflow_err), 1);
        check("empty_after_overflow", int'(bus.empty), 0);
        mode3_active = 1;
        drain();
        check("empty_after_overflow_drain", int'(bus.empty), 1);
        check("overflow_sticky", int'(overflow_err), 1);

        reset = 1;
        tick();
        check("overflow_cleared_by_reset", int'(overflow_err), 0);
        reset = 0;
        tick();
        bus.write_en = 1;
        bus.write_data = rand_tile();
        do_flush(3'd0);
        bus.write_en = 0;
        check("empty_after_flush_write", int'(bus.empty), 1);
        check("overflow_after_flush_write", int'(overflow_err), 0);
        repeat (3) tick();
        check("still_empty_after_flush_write", int'(bus.empty), 1);

        do_flush(3'd0);
        while (last_x < 80 && x_exp < LINE) push_tile(rand_tile());
        #3 reset = 1;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        tick();
        tick();
        reset = 0;
        tick();
        do_flush(3'd0);
        push_tile(rand_tile());
        drain();
        check("restart_last_x", last_x, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bg_pixel_shifter.md
Name: bg_pixel_shifter

Overview:
- Consumer end of the background pixel FIFO interface. Accepts 8-pixel parallel pushes from the tile fetcher and exposes `empty` back to it.
- Pops one pixel per dot during mode 3 and discards the SCX fine-scroll pixels at line start.
- Emits registered pixel color and x position toward the LCD and mixer, and signals end of the 160-pixel line.

Parameters:
- NUM_PIXELS, 8, parallel push width (pixels per tile row).
- LINE_WIDTH, 160, visible pixels per scanline (GB_SCREEN_WIDTH).

Ports:
- clk  in  1  system clock (one dot per cycle when not stalled).
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  start of mode 3; clears the buffer and relatches fine scroll.
- mode3_active  in  1  PPU is in mode 3; pops are allowed only while high.
- stall  in  1  sprite-fetch stall; freezes pops and the state machine.
- scx_fine  in  3  SCX[2:0], sampled on flush.
- write_en  in  1  fetcher push strobe.
- write_data  in  NUM_PIXELS x pixel_t  pushed pixels; index 0 is leftmost.
- empty  out  1  combinational; high when count == 0.
- pix_valid  out  1  registered; a visible pixel is presented this cycle.
- pix_color  out  2  registered color_id_t of the presented pixel.
- pix_x  out  8  registered screen x (0..159) of the presented pixel.
- line_done  out  1  registered; high once pixel 159 has been emitted, held until flush or reset.
- overflow_err  out  1  sticky; set when write_en arrives while count != 0.

Behaviour:
- Reset: count=0, rd_ptr=0, discard_cnt=0, x_cnt=0, state=IDLE. All outputs 0 except empty=1.
- Storage: NUM_PIXELS x pixel_t register array, 4-bit count (0..8), 3-bit rd_ptr.
- Push:
  - Accepted only when write_en && count==0.
  - Loads all 8 entries, sets count=8, rd_ptr=0.
  - Pushed data is poppable no earlier than the next cycle, so a push and a pop never coincide.
  - write_en with count!=0: data is ignored, count is unchanged, overflow_err is set. overflow_err clears only on reset.
- Pop condition: mode3_active && !stall && count>0 && state in {DISCARD, SHIFT}.
  - Each pop: count-1, rd_ptr+1 (wraps 7 to 0).
- State machine:
  - IDLE: flush moves to DISCARD if scx_fine != 0, otherwise to SHIFT. discard_cnt <= scx_fine.
  - DISCARD:
    - Each pop decrements discard_cnt with pix_valid=0.
    - A pop while discard_cnt==1 moves to SHIFT.
  - SHIFT:
    - Each pop registers pix_valid=1, pix_color=entry.color, pix_x=x_cnt, then x_cnt+1.
    - A pop with x_cnt==LINE_WIDTH-1 moves to DONE and sets line_done next cycle along with the last pixel.
  - DONE: no pops. Remaining entries stay in place, and empty may stay low.
- Output latency: pixel values appear the cycle after the pop cycle. pix_valid is a one-cycle pulse per pixel and is 0 on any cycle without a SHIFT pop.
- Stall, or mode3_active low: count, pointers and state hold, and pix_valid=0 on the following cycle.
- Flush:
  - Highest priority after reset, from any state.
  - Clears count, rd_ptr and x_cnt, and relatches discard_cnt. Clears line_done and pix_valid.
  - write_en in the same cycle as flush is dropped and does not set overflow_err.
- Fine scroll of 7: the first 7 pops of the first tile are discarded, and pixel 0 comes from entry 7.
- Arithmetic: x_cnt is 8-bit and never exceeds 159 because DONE blocks further pops. All counters are unsigned with no wrap beyond the stated ranges.
- Reset mid-line: immediate asynchronous clear to reset values. No pixel is emitted on the reset-release cycle.

Decomposition:
- ppu_types_pkg (existing) supplies pixel_t, color_id_t and GB_SCREEN_WIDTH.
- New ppu_shifter_types_pkg holds the state enum (SHIFTER_IDLE, SHIFTER_DISCARD, SHIFTER_SHIFT, SHIFTER_DONE).
- One sub-module is natural: pixel_buf8, the 8-entry parallel-load / serial-read buffer containing count, rd_ptr, empty and overflow detection. The top level holds the state machine and output registers.

Test Plan:
- scx_fine=0, flush, push tile {c0..c7}=3,2,1,0,3,2,1,0 -> cycles +1..+8 show pix_x 0..7 with those colors; empty rises after the 8th pop.
- scx_fine=5, flush, push two tiles -> 5 pops produce no pix_valid; first pix_valid has pix_x=0 with color of tile0 entry 5; tile1 entry 0 appears at pix_x=3.
- Stall asserted for 6 cycles mid-tile after pix_x=2 -> no pix_valid during the stall; next pixel is pix_x=3 with no skip or duplicate.
- 20 tiles, scx_fine=0 -> exactly 160 pix_valid pulses; line_done rises with pix_x=159 and stays high; a 21st push is accepted, nothing is emitted, and empty stays low.
- Push while count=4 -> overflow_err=1, count stays 4, emitted colors are unchanged; flush with write_en in the same cycle -> count=0 and overflow_err is not set by that write.
- Reset asserted at pix_x=80 -> all outputs 0 and empty=1 asynchronously; after release plus flush, pix_x restarts at 0.
